// File: rtl/apple_placer.sv
`default_nettype none
// ============================================================================
// Module      : apple_placer
// Description : Chooses a free interior cell for the snake apple using an
//               8-bit LFSR random search, then a raster-scan fallback.
//               Optional macro APPLE_RELOCATE_EN: re-place the apple on its
//               own when a border change leaves it outside the interior.
// Revision    : 1.0 - initial release
// ============================================================================
module apple_placer #(
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         MAX_TRIES = 32
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       place_req,
   input  logic [3:0] XMAX,
   input  logic [3:0] XMIN,
   input  logic [3:0] YMAX,
   input  logic [3:0] YMIN,
   input  logic       occupied,
   output logic [3:0] query_x,
   output logic [3:0] query_y,
   output logic [3:0] apple_x,
   output logic [3:0] apple_y,
   output logic       busy,
   output logic       done,
   output logic       board_full
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEARCH = 3'd1,
      S_SCAN   = 3'd2,
      S_DONE   = 3'd3,
      S_FULL   = 3'd4
   } state_t;

   localparam logic [7:0] c_max_tries = 8'(MAX_TRIES);
   localparam logic [3:0] c_reset_x   = 4'd5;
   localparam logic [3:0] c_reset_y   = 4'd3;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_lfsr;
   logic [7:0] r_tries;
   logic [3:0] r_scan_x;
   logic [3:0] r_scan_y;
   logic [3:0] r_apple_x;
   logic [3:0] r_apple_y;
   logic       r_board_full;

   logic       w_fb;
   logic [7:0] w_tries_inc;
   logic       w_empty;
   logic       w_free;
   logic       w_start;
   logic       w_x_wrap;
   logic       w_y_end;
   logic       w_latch;
   logic       w_load_scan;
   logic       w_try_inc;
   logic       w_scan_adv;

   function automatic logic is_interior(input logic [3:0] x, input logic [3:0] y,
                                        input logic [3:0] xmax, input logic [3:0] xmin,
                                        input logic [3:0] ymax, input logic [3:0] ymin);
      return (x > xmin) && (x < xmax) && (y > ymin) && (y < ymax);
   endfunction

   // Fibonacci LFSR, taps 8,6,5,4
   assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_tries_inc = r_tries + 8'd1;

   // 5-bit compares so XMIN/YMIN = 15 cannot wrap
   assign w_empty  = ({1'b0, XMAX} <= ({1'b0, XMIN} + 5'd1)) ||
                     ({1'b0, YMAX} <= ({1'b0, YMIN} + 5'd1));
   assign w_x_wrap = ({1'b0, r_scan_x} + 5'd1) >= {1'b0, XMAX};
   assign w_y_end  = ({1'b0, r_scan_y} + 5'd1) >= {1'b0, YMAX};

   always_comb begin
      query_x = r_apple_x;
      query_y = r_apple_y;
      if (r_state == S_SEARCH) begin
         query_x = r_lfsr[3:0];
         query_y = r_lfsr[7:4];
      end else if (r_state == S_SCAN) begin
         query_x = r_scan_x;
         query_y = r_scan_y;
      end
   end

   assign w_free = is_interior(query_x, query_y, XMAX, XMIN, YMAX, YMIN) && !occupied;

`ifdef APPLE_RELOCATE_EN
   logic w_apple_in;
   assign w_apple_in = is_interior(r_apple_x, r_apple_y, XMAX, XMIN, YMAX, YMIN);
   assign w_start    = place_req || !w_apple_in;
`else
   assign w_start    = place_req;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_load_scan = 1'b0;
      w_try_inc   = 1'b0;
      w_scan_adv  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            if (w_empty) begin
               w_state_nxt = S_FULL;
            end else if (w_free) begin
               w_latch     = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_tries_inc == c_max_tries) begin
               w_load_scan = 1'b1;
               w_state_nxt = S_SCAN;
            end else begin
               w_try_inc   = 1'b1;
            end
         end
         S_SCAN: begin
            if (w_free) begin
               w_latch     = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_x_wrap && w_y_end) begin
               w_state_nxt = S_FULL;
            end else begin
               w_scan_adv  = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_FULL:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_lfsr       <= LFSR_SEED;
         r_tries      <= 8'd0;
         r_scan_x     <= 4'd0;
         r_scan_y     <= 4'd0;
         r_apple_x    <= c_reset_x;
         r_apple_y    <= c_reset_y;
         r_board_full <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[6:0], w_fb};
         if (r_state == S_IDLE && w_start) begin
            r_tries      <= 8'd0;
            r_board_full <= 1'b0;
         end
         if (w_try_inc) r_tries <= w_tries_inc;
         if (w_load_scan) begin
            r_scan_x <= XMIN + 4'd1;
            r_scan_y <= YMIN + 4'd1;
         end
         // Borders are live: only the wrap re-reads XMIN
         if (w_scan_adv) begin
            if (w_x_wrap) begin
               r_scan_x <= XMIN + 4'd1;
               r_scan_y <= r_scan_y + 4'd1;
            end else begin
               r_scan_x <= r_scan_x + 4'd1;
            end
         end
         if (w_latch) begin
            r_apple_x <= query_x;
            r_apple_y <= query_y;
         end
         if (r_state == S_FULL) r_board_full <= 1'b1;
      end
   end

   assign apple_x    = r_apple_x;
   assign apple_y    = r_apple_y;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);
   assign board_full = r_board_full;

endmodule
`default_nettype wire

// File: tb/tb_apple_placer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apple_placer
// Description : Scoreboard bench for apple_placer (MAX_TRIES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apple_placer;

   localparam int c_tries = 4;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       place_req = 1'b0;
   logic [3:0] XMAX = 4'd14, XMIN = 4'd0, YMAX = 4'd10, YMIN = 4'd0;
   logic       occupied;
   logic [3:0] query_x, query_y, apple_x, apple_y;
   logic       busy, done, board_full;

   int         occ_mode = 0;
   logic [3:0] free_x = 4'd0, free_y = 4'd0;
   int         errors = 0;
   int         checks = 0;
   logic [3:0] exp_ax = 4'd5, exp_ay = 4'd3;
   logic [7:0] m_lfsr;

   typedef struct {
      bit         full;
      logic [3:0] x;
      logic [3:0] y;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   apple_placer #(.LFSR_SEED(8'hA5), .MAX_TRIES(c_tries)) dut (
      .clk(clk), .nrst(nrst), .place_req(place_req),
      .XMAX(XMAX), .XMIN(XMIN), .YMAX(YMAX), .YMIN(YMIN),
      .occupied(occupied), .query_x(query_x), .query_y(query_y),
      .apple_x(apple_x), .apple_y(apple_y),
      .busy(busy), .done(done), .board_full(board_full)
   );

   always #5 clk = ~clk;

   // Body tracker stand-in: 0 none, 1 all but (free_x,free_y), 2 all cells
   assign occupied = (occ_mode == 2) ||
                     (occ_mode == 1 && !(query_x == free_x && query_y == free_y));

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   always @(posedge clk or negedge nrst) begin
      if (!nrst) m_lfsr <= 8'hA5;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   function automatic bit m_free(input int x, input int y);
      bit in_b, occ_b;
      in_b  = (x > int'(XMIN)) && (x < int'(XMAX)) && (y > int'(YMIN)) && (y < int'(YMAX));
      occ_b = (occ_mode == 2) || (occ_mode == 1 && !(x == int'(free_x) && y == int'(free_y)));
      return in_b && !occ_b;
   endfunction

   // Expected outcome and busy length for a request issued with LFSR value l0
   function automatic exp_t predict(input logic [7:0] l0);
      exp_t       e;
      logic [7:0] l;
      l     = lfsr_next(l0);
      e.full = 1'b1;
      e.x    = exp_ax;
      e.y    = exp_ay;
      e.cyc  = 0;
      if (int'(XMAX) <= int'(XMIN) + 1 || int'(YMAX) <= int'(YMIN) + 1) begin
         e.cyc = 2;
         return e;
      end
      for (int t = 0; t < c_tries; t++) begin
         e.cyc++;
         if (m_free(int'(l[3:0]), int'(l[7:4]))) begin
            e.full = 1'b0; e.x = l[3:0]; e.y = l[7:4]; e.cyc++;
            return e;
         end
         l = lfsr_next(l);
      end
      for (int y = int'(YMIN) + 1; y < int'(YMAX); y++) begin
         for (int x = int'(XMIN) + 1; x < int'(XMAX); x++) begin
            e.cyc++;
            if (m_free(x, y)) begin
               e.full = 1'b0; e.x = 4'(x); e.y = 4'(y); e.cyc++;
               return e;
            end
         end
      end
      e.cyc++;
      return e;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle
   task automatic run_place(input string tag, input logic [3:0] xmax, input logic [3:0] xmin,
                            input logic [3:0] ymax, input logic [3:0] ymin,
                            input int mode, input logic [3:0] fx, input logic [3:0] fy,
                            input bit repulse);
      exp_t e;
      int   cyc, dones;
      cyc   = 0;
      dones = 0;
      XMAX = xmax; XMIN = xmin; YMAX = ymax; YMIN = ymin;
      occ_mode = mode; free_x = fx; free_y = fy;
      sb.push_back(predict(m_lfsr));
      place_req = 1'b1;
      @(negedge clk);
      place_req = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         cyc++;
         if (done) dones++;
         place_req = (repulse && i == 0);
         @(negedge clk);
      end
      place_req = 1'b0;
      e = sb.pop_front();
      check({tag, ":done_count"}, dones, e.full ? 0 : 1);
      check({tag, ":board_full"}, int'(board_full), int'(e.full));
      check({tag, ":apple_x"}, int'(apple_x), int'(e.x));
      check({tag, ":apple_y"}, int'(apple_y), int'(e.y));
      check({tag, ":busy_cycles"}, cyc, e.cyc);
      exp_ax = e.x;
      exp_ay = e.y;
   endtask

   initial begin
      int busy_seen;
      repeat (2) @(negedge clk);
      check("rst:apple_x", int'(apple_x), 5);
      check("rst:apple_y", int'(apple_y), 3);
      check("rst:busy", int'(busy), 0);
      check("rst:done", int'(done), 0);
      check("rst:board_full", int'(board_full), 0);
      check("rst:query_x", int'(query_x), 5);
      nrst = 1'b1;
      @(negedge clk);

      run_place("open_board", 4'd14, 4'd0, 4'd10, 4'd0, 0, 4'd0, 4'd0, 1'b0);
      run_place("one_free", 4'd8, 4'd0, 4'd4, 4'd0, 1, 4'd3, 4'd2, 1'b0);
      run_place("all_occ", 4'd8, 4'd0, 4'd4, 4'd0, 2, 4'd0, 4'd0, 1'b0);
      run_place("clear_full", 4'd8, 4'd0, 4'd4, 4'd0, 0, 4'd0, 4'd0, 1'b0);
      run_place("no_interior", 4'd1, 4'd0, 4'd10, 4'd0, 0, 4'd0, 4'd0, 1'b0);
      run_place("busy_req", 4'd8, 4'd0, 4'd4, 4'd0, 1, 4'd3, 4'd2, 1'b1);
      run_place("shifted", 4'd12, 4'd6, 4'd15, 4'd9, 1, 4'd7, 4'd14, 1'b0);

      // Reset in the middle of the raster scan
      XMAX = 4'd8; XMIN = 4'd0; YMAX = 4'd4; YMIN = 4'd0; occ_mode = 2;
      place_req = 1'b1;
      @(negedge clk);
      place_req = 1'b0;
      repeat (6) @(negedge clk);
      check("midscan:busy_before", int'(busy), 1);
      nrst = 1'b0;
      #1;
      check("midscan:apple_x", int'(apple_x), 5);
      check("midscan:apple_y", int'(apple_y), 3);
      check("midscan:busy", int'(busy), 0);
      check("midscan:board_full", int'(board_full), 0);
      @(negedge clk);
      nrst = 1'b1;
      exp_ax = 4'd5;
      exp_ay = 4'd3;
      @(negedge clk);

      // Park the apple at (12,8), then shrink the border around it
      run_place("to_12_8", 4'd14, 4'd0, 4'd10, 4'd0, 1, 4'd12, 4'd8, 1'b0);
      XMAX = 4'd9; YMAX = 4'd5; occ_mode = 0;
      busy_seen = 0;
`ifdef APPLE_RELOCATE_EN
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (!busy && busy_seen > 0) break;
      end
      check("reloc:searched", int'(busy_seen > 0), 1);
      check("reloc:interior", int'(apple_x > XMIN && apple_x < XMAX &&
                                   apple_y > YMIN && apple_y < YMAX), 1);
`else
      repeat (6) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      check("hold:busy", busy_seen, 0);
      check("hold:apple_x", int'(apple_x), 12);
      check("hold:apple_y", int'(apple_y), 8);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
